// File: rtl/fifo_wr_rr_arbiter.sv
// rtl/fifo_wr_rr_arbiter.sv - round-robin packet-locked write arbiter for one FIFO write port
// Optional stall counter output is enabled by defining FIFO_WR_ARB_STAT_EN.
module fifo_wr_rr_arbiter #(
  parameter  int NUM   = 4,
  parameter  int DSIZE = 18,
  localparam int ISIZE = $clog2(NUM)
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NUM*DSIZE-1:0] s_data,
  input  logic [NUM-1:0]       s_valid,
  input  logic [NUM-1:0]       s_last,
  output logic [NUM-1:0]       s_ready,
  input  logic                 fifo_full,
  output logic [DSIZE-1:0]     fifo_din,
  output logic                 fifo_wr_en,
  output logic [ISIZE-1:0]     grant_id,
  output logic                 busy
`ifdef FIFO_WR_ARB_STAT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t           state_q;
  logic [ISIZE-1:0] grant_q;
  logic [ISIZE-1:0] rr_ptr_q;

  logic [DSIZE-1:0] src_data [NUM];
  logic [ISIZE-1:0] pick_idx;
  logic             pick_found;
  logic             cur_valid;
  logic             cur_last;
  logic             xfer;

  for (genvar gi = 0; gi < NUM; gi++) begin : g_slice
    assign src_data[gi] = s_data[gi*DSIZE +: DSIZE];
  end

  // Scan from the source after the last completer, wrapping at NUM.
  always_comb begin
    int cand_int;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_int   = 0;
    for (int k = 1; k <= NUM; k++) begin
      cand_int = (int'(rr_ptr_q) + k) % NUM;
      if (!pick_found && s_valid[cand_int[ISIZE-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand_int[ISIZE-1:0];
      end
    end
  end

  assign cur_valid  = s_valid[grant_q];
  assign cur_last   = s_last[grant_q];
  assign xfer       = (state_q == ST_LOCK) && cur_valid && !fifo_full;
  assign fifo_wr_en = xfer;
  assign fifo_din   = src_data[grant_q];
  assign grant_id   = grant_q;
  assign busy       = (state_q == ST_LOCK);

  always_comb begin
    s_ready = '0;
    if (state_q == ST_LOCK) begin
      s_ready[grant_q] = ~fifo_full;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= ISIZE'(NUM - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            grant_q <= pick_idx;
            state_q <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (xfer && cur_last) begin
            rr_ptr_q <= grant_q;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STAT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else if ((state_q == ST_LOCK) && cur_valid && fifo_full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// tb/tb_fifo_wr_rr_arbiter.sv - self-checking bench for fifo_wr_rr_arbiter
// Source beat queues plus a cycle-level arbitration model checked every cycle.
module tb_fifo_wr_rr_arbiter;
  localparam int NUM   = 4;
  localparam int DSIZE = 18;
  localparam int ISIZE = 2;

  logic                 clock = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM*DSIZE-1:0] s_data = '0;
  logic [NUM-1:0]       s_valid = '0;
  logic [NUM-1:0]       s_last = '0;
  logic [NUM-1:0]       s_ready;
  logic                 fifo_full = 1'b0;
  logic [DSIZE-1:0]     fifo_din;
  logic                 fifo_wr_en;
  logic [ISIZE-1:0]     grant_id;
  logic                 busy;
`ifdef FIFO_WR_ARB_STAT_EN
  logic [15:0]          stall_cnt;
`endif

  always #5 clock = ~clock;

  fifo_wr_rr_arbiter #(.NUM(NUM), .DSIZE(DSIZE)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .fifo_full (fifo_full),
    .fifo_din  (fifo_din),
    .fifo_wr_en(fifo_wr_en),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef FIFO_WR_ARB_STAT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [DSIZE:0] srcq [NUM][$];
  int  vprob [NUM];
  bit  cur_full = 1'b0;
  bit  cur_rst_n = 1'b0;
  bit  armed = 1'b0;

  bit  m_busy = 1'b0;
  int  m_grant = 0;
  int  m_rr = NUM - 1;
  int  m_stall = 0;

  int  dut_grants[$];
  bit  dut_in_pkt = 1'b0;
  int  beats_written = 0;
  bit  obs_busy;
  int  obs_grant;
  bit  obs_wr;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner is the requester at the smallest rotated distance past rr.
  function automatic int pick(input logic [NUM-1:0] v, input int rr);
    int best = -1;
    int bestd = NUM;
    for (int i = 0; i < NUM; i++) begin
      int d = (i - rr - 1 + 2*NUM) % NUM;
      if (v[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NUM; i++) if (srcq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic load_pkt(input int src, input int len, input int tag);
    for (int b = 0; b < len; b++)
      srcq[src].push_back({(b == len - 1), 2'(src), 8'(tag), 8'(b)});
  endtask

  task automatic step();
    logic [NUM-1:0] er;
    bit             ew;
    logic [DSIZE:0] beat;
    beat = '0;
    @(negedge clock);
    rst_n     = cur_rst_n;
    fifo_full = cur_full;
    for (int i = 0; i < NUM; i++) begin
      if (srcq[i].size() > 0 && int'($urandom_range(99)) < vprob[i]) begin
        s_valid[i] = 1'b1;
        s_data[i*DSIZE +: DSIZE] = srcq[i][0][DSIZE-1:0];
        s_last[i] = srcq[i][0][DSIZE];
      end else begin
        s_valid[i] = 1'b0;
        s_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
        s_last[i] = 1'($urandom_range(1));
      end
    end
    #1;
    er = '0;
    ew = 1'b0;
    if (m_busy) begin
      er[m_grant] = ~cur_full;
      ew = s_valid[m_grant] & ~cur_full;
    end
    if (armed) begin
      check("s_ready", s_ready, er);
      check("wr_en", fifo_wr_en, ew);
      check("busy", busy, m_busy);
      check("grant_id", grant_id, m_grant);
      if (ew) check("din", fifo_din, srcq[m_grant][0][DSIZE-1:0]);
`ifdef FIFO_WR_ARB_STAT_EN
      check("stall_cnt", stall_cnt, m_stall);
`endif
    end
    obs_busy  = busy;
    obs_grant = grant_id;
    obs_wr    = fifo_wr_en;
    if (!cur_rst_n) dut_in_pkt = 1'b0;
    else if (fifo_wr_en) begin
      if (!dut_in_pkt) dut_grants.push_back(int'(grant_id));
      dut_in_pkt = !s_last[grant_id];
    end
    if (fifo_wr_en) beats_written++;
`ifdef FIFO_WR_ARB_STAT_EN
    if (!cur_rst_n) m_stall = 0;
    else if (m_busy && s_valid[m_grant] && cur_full && m_stall < 65535) m_stall++;
`endif
    if (ew) beat = srcq[m_grant].pop_front();
    if (!cur_rst_n) begin
      m_busy = 1'b0; m_grant = 0; m_rr = NUM - 1;
    end else if (!m_busy) begin
      if (s_valid != '0) begin
        m_grant = pick(s_valid, m_rr);
        m_busy  = 1'b1;
      end
    end else if (ew && beat[DSIZE]) begin
      m_rr   = m_grant;
      m_busy = 1'b0;
    end
  endtask

  task automatic do_reset();
    cur_rst_n = 1'b0;
    step();
    armed     = 1'b1;
    cur_rst_n = 1'b1;
    dut_grants.delete();
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (pending() && n < bound) begin
      step();
      n++;
    end
    check({name, "_drain_timeout"}, pending(), 0);
  endtask

  initial begin
    int cyc;
    int nowr;
    int base;
    int total;
    for (int i = 0; i < NUM; i++) vprob[i] = 100;

    // Idle after reset
    do_reset();
    for (int k = 0; k < 10; k++) step();
    check("idle_busy", obs_busy, 0);
    check("idle_grant", obs_grant, 0);
    check("idle_wr", obs_wr, 0);
    check("idle_ready", s_ready, 0);

    // Rotation over all sources with 3-beat packets
    do_reset();
    load_pkt(0, 3, 1); load_pkt(1, 3, 2); load_pkt(2, 3, 3); load_pkt(3, 3, 4); load_pkt(0, 3, 5);
    cyc = 0;
    while (pending() && cyc < 100) begin
      step();
      cyc++;
    end
    check("rot_cycles", cyc, 20);
    check("rot_npkts", dut_grants.size(), 5);
    if (dut_grants.size() == 5) begin
      check("rot_g0", dut_grants[0], 0);
      check("rot_g1", dut_grants[1], 1);
      check("rot_g2", dut_grants[2], 2);
      check("rot_g3", dut_grants[3], 3);
      check("rot_g4", dut_grants[4], 0);
    end

    // Back-pressure on packet cycles 2..5 of source 2
    do_reset();
    load_pkt(2, 8, 7);
    base = beats_written;
    nowr = 0;
    cyc  = 0;
    while (pending() && cyc < 50) begin
      cur_full = (cyc >= 2 && cyc <= 5);
      step();
      if (cyc >= 1 && !obs_wr) nowr++;
      cyc++;
    end
    cur_full = 1'b0;
    check("bp_stalled_cycles", nowr, 4);
    check("bp_beats", beats_written - base, 8);
    check("bp_grant", obs_grant, 2);
`ifdef FIFO_WR_ARB_STAT_EN
    check("bp_stall_cnt", stall_cnt, 4);
`endif

    // Single-beat packet then contention between 1 and 3
    do_reset();
    load_pkt(1, 1, 8); load_pkt(1, 2, 9); load_pkt(3, 2, 10);
    drain("single", 50);
    check("single_npkts", dut_grants.size(), 3);
    if (dut_grants.size() == 3) begin
      check("single_g0", dut_grants[0], 1);
      check("single_g1", dut_grants[1], 3);
      check("single_g2", dut_grants[2], 1);
    end

    // Reset on the 2nd beat of a source-3 packet
    do_reset();
    load_pkt(3, 5, 11);
    step();
    step();
    cur_rst_n = 1'b0;
    step();
    cur_rst_n = 1'b1;
    dut_grants.delete();
    load_pkt(0, 2, 12);
    step();
    check("rst_busy", obs_busy, 0);
    check("rst_grant", obs_grant, 0);
    drain("rst", 50);
    check("rst_npkts", dut_grants.size(), 2);
    if (dut_grants.size() == 2) begin
      check("rst_first", dut_grants[0], 0);
      check("rst_second", dut_grants[1], 3);
    end

    // Random traffic with random back-pressure
    do_reset();
    base  = beats_written;
    total = 0;
    for (int i = 0; i < NUM; i++) vprob[i] = 40 + int'($urandom_range(60));
    for (int r = 0; r < 40; r++) begin
      int len = 1 + int'($urandom_range(5));
      load_pkt(int'($urandom_range(NUM - 1)), len, 20 + r);
      total += len;
    end
    cyc = 0;
    while (pending() && cyc < 4000) begin
      cur_full = ($urandom_range(3) == 0);
      if (cyc < 1000 && $urandom_range(15) == 0) begin
        int len = 1 + int'($urandom_range(5));
        load_pkt(int'($urandom_range(NUM - 1)), len, 100 + (cyc % 100));
        total += len;
      end
      step();
      cyc++;
    end
    cur_full = 1'b0;
    check("rand_drain_timeout", pending(), 0);
    check("rand_beats", beats_written - base, total);
    for (int i = 0; i < NUM; i++) vprob[i] = 100;

`ifdef FIFO_WR_ARB_STAT_EN
    // Saturation of the stall counter
    do_reset();
    load_pkt(1, 2, 200);
    cur_full = 1'b1;
    nowr = 0;
    for (int k = 0; k < 70000; k++) begin
      step();
      if (obs_wr) nowr++;
    end
    check("sat_wr_count", nowr, 0);
    check("sat_stall_cnt", stall_cnt, 65535);
    cur_full = 1'b0;
    drain("sat", 20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_rr_arbiter.md
# fifo_wr_rr_arbiter

Round-robin, packet-locked write arbiter that lets NUM independent streaming sources share the write port of one FIFO wrapper instance (xilinx FIFO IP wrapper, same clock domain on its write side). A source holds the grant from its first accepted beat until its `last` beat is written. Between packets the grant rotates fairly. The block produces `din`/`wr_en` directly from the granted source and honours the FIFO `full` flag, so no beat is ever dropped or duplicated.

## Interface
- `NUM`, 4: number of requesters, 2..16.
- `DSIZE`, 18: data width, equal to the FIFO `DSIZE`.
- `ISIZE`, `$clog2(NUM)`: grant index width (derived, not overridden).

- `clock`  in  1  single clock; FIFO `wr_clk` is driven from the same net.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_data`  in  NUM*DSIZE  packed source data; source i occupies bits [i*DSIZE +: DSIZE].
- `s_valid`  in  NUM  per-source beat valid.
- `s_last`  in  NUM  per-source end-of-packet, qualified by `s_valid`.
- `s_ready`  out  NUM  per-source ready, one-hot or zero.
- `fifo_full`  in  1  FIFO `full`.
- `fifo_din`  out  DSIZE  to FIFO `din`.
- `fifo_wr_en`  out  1  to FIFO `wr_en`.
- `grant_id`  out  ISIZE  index of the current or last granted source.
- `busy`  out  1  a packet is in progress (state LOCK).

## Operation
- FSM with 2 states, IDLE and LOCK; reset state is IDLE.
- `rr_ptr` is the index of the last source that completed a packet. Its reset value is NUM-1, so source 0 has the first priority after reset.
- IDLE:
  - If any `s_valid` is high, select the first set bit scanning `rr_ptr+1, rr_ptr+2, ...` modulo NUM.
  - Register that index into `grant_id` and go to LOCK on the next edge.
  - No transfer occurs in IDLE, and all `s_ready` bits are 0 in IDLE.
- LOCK:
  - `s_ready[grant_id] = ~fifo_full`. All other `s_ready` bits are 0.
  - Transfer condition: `xfer = s_valid[grant_id] & ~fifo_full`.
  - `fifo_wr_en = xfer`; `fifo_din = s_data[grant_id*DSIZE +: DSIZE]`, combinational mux.
  - On `xfer & s_last[grant_id]`: set `rr_ptr <= grant_id` and go to IDLE.
- `fifo_wr_en` is never high while `fifo_full` is high.
- Once granted, a source holds the grant indefinitely while its `s_valid` is low. Sources must not stall mid-packet forever.
- A single-beat packet (`s_last` on the first beat) is legal and takes one LOCK cycle.

## Timing
- Reset values:
  - `s_ready` = 0, `fifo_wr_en` = 0, `busy` = 0, `grant_id` = 0.
  - `fifo_din` = the source-0 slice (don't-care while `wr_en` = 0).
  - `rr_ptr` = NUM-1.
- Arbitration latency: a request seen in IDLE at cycle t gives `busy` = 1 and a first possible transfer at cycle t+1.
- Throughput inside a packet: 1 beat per cycle while `fifo_full` = 0.
- Packet overhead: exactly 1 IDLE cycle between consecutive packets, even from the same source.
- Back-pressure: `fifo_full` affects `s_ready` and `fifo_wr_en` in the same cycle (combinational). There are no extra bubbles when `full` deasserts.
- `fifo_full` is high while in IDLE: arbitration still happens and the grant is taken, but no transfer occurs until `full` clears.
- `rst_n` low during LOCK:
  - Next edge: IDLE, `rr_ptr` = NUM-1, outputs at their reset values.
  - The partial packet already in the FIFO is left as is.
- Simultaneous requests: the lowest rotated distance from `rr_ptr` wins. Requests that arrive while in LOCK are only evaluated in the next IDLE.

## Configuration
- `FIFO_WR_ARB_STAT_EN`
  - Defined: adds output `stall_cnt [15:0]` (reset 0). It increments by 1 every cycle where `busy & s_valid[grant_id] & fifo_full`, saturates at 16'hFFFF, and clears only on reset.
  - Not defined: the port and its counter are absent. Arbitration behaviour is identical in both builds.

## Test plan
- Reset release, no requests for 10 cycles -> all outputs 0, `busy` stays 0, `grant_id` = 0.
- NUM=4, sources 0..3 each hold `s_valid` high with 3-beat packets, `full` = 0 -> grant order 0,1,2,3,0.
  - Each packet takes 3 `wr_en` cycles followed by 1 idle cycle.
  - The FIFO receives unbroken 3-beat groups in that order.
- Source 2 is granted; `fifo_full` is high for cycles 2..5 of its packet -> `wr_en` = 0 and `s_ready[2]` = 0 on exactly those cycles.
  - No beat is lost.
  - With the macro defined, `stall_cnt` = 4.
- Source 1 sends a single-beat packet while sources 1 and 3 both request again next -> after source 1, source 3 is granted before source 1.
- `rst_n` is pulsed low on the 2nd beat of a 5-beat packet from source 3 -> next cycle IDLE, `busy` = 0; the next grant goes to source 0 if it is requesting.
- `fifo_full` is forced high for 70000 cycles with a pending beat (macro defined) -> `stall_cnt` saturates at 65535 and `wr_en` stays 0 throughout.
